// File: rtl/array_arbiter.sv
// Two-port round-robin arbiter sharing one array memory between two Array-interface requesters.
// The granted requester is routed combinationally to the memory until its transaction handshakes.
`ifndef intN
`define intN 32
`endif
`ifndef addrN
`define addrN 8
`endif
`ifndef intT
`define intT logic [`intN-1:0]
`endif
`ifndef addrT
`define addrT logic [`addrN-1:0]
`endif

module array_arbiter #(
    parameter bit PRIO0 = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  `addrT r0_addr,
    input  logic  r0_we,
    input  `intT  r0_di,
    input  logic  r0_valid,
    output `intT  r0_do,
    output logic  r0_ready,
    input  `addrT r1_addr,
    input  logic  r1_we,
    input  `intT  r1_di,
    input  logic  r1_valid,
    output `intT  r1_do,
    output logic  r1_ready,
    output `addrT arr_addr,
    output logic  arr_we,
    output `intT  arr_di,
    output logic  arr_valid,
    input  `intT  arr_do,
    input  logic  arr_ready,
    output logic  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   prio;   // 1: requester 0 wins a tie, 0: requester 1 wins
    logic   done;

    assign done  = arr_valid && arr_ready;
    assign busy  = (state != IDLE);
    assign r0_do = arr_do;
    assign r1_do = arr_do;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        arr_addr  = '0;
        arr_we    = 1'b0;
        arr_di    = '0;
        arr_valid = 1'b0;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        case (state)
            GRANT0: begin
                arr_addr  = r0_addr;
                arr_we    = r0_we;
                arr_di    = r0_di;
                arr_valid = r0_valid;
                r0_ready  = arr_ready;
            end
            GRANT1: begin
                arr_addr  = r1_addr;
                arr_we    = r1_we;
                arr_di    = r1_di;
                arr_valid = r1_valid;
                r1_ready  = arr_ready;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= PRIO0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_valid && (!r1_valid || prio))
                        state <= GRANT0;
                    else if (r1_valid)
                        state <= GRANT1;
                end
                GRANT0: begin
                    // On completion the pending valid of the winner is stale; only hand over or idle.
                    if (done) begin
                        prio  <= 1'b0;
                        state <= r1_valid ? GRANT1 : IDLE;
                    end else if (!r0_valid) begin
                        state <= IDLE;
                    end
                end
                GRANT1: begin
                    if (done) begin
                        prio  <= 1'b1;
                        state <= r0_valid ? GRANT0 : IDLE;
                    end else if (!r1_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_arbiter.sv
// Directed self-checking bench for array_arbiter with a small behavioural memory model.
`ifndef intN
`define intN 32
`endif
`ifndef addrN
`define addrN 8
`endif

module tb_array_arbiter;

    localparam int DW = `intN;
    localparam int AW = `addrN;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] r0_addr, r1_addr, arr_addr;
    logic          r0_we, r1_we, arr_we;
    logic [DW-1:0] r0_di, r1_di, arr_di;
    logic          r0_valid, r1_valid, arr_valid;
    logic [DW-1:0] r0_do, r1_do, arr_do;
    logic          r0_ready, r1_ready, arr_ready;
    logic          busy;
    logic          stall;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // Memory model: ready whenever presented unless stalled, write on the handshake edge.
    assign arr_ready = arr_valid && !stall;
    assign arr_do    = mem[arr_addr];
    always @(posedge clk)
        if (arr_valid && arr_ready && arr_we) mem[arr_addr] <= arr_di;

    array_arbiter #(.PRIO0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_we(r0_we), .r0_di(r0_di), .r0_valid(r0_valid),
        .r0_do(r0_do), .r0_ready(r0_ready),
        .r1_addr(r1_addr), .r1_we(r1_we), .r1_di(r1_di), .r1_valid(r1_valid),
        .r1_do(r1_do), .r1_ready(r1_ready),
        .arr_addr(arr_addr), .arr_we(arr_we), .arr_di(arr_di), .arr_valid(arr_valid),
        .arr_do(arr_do), .arr_ready(arr_ready), .busy(busy)
    );

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0;
        r0_valid = 0; r0_we = 0; r0_addr = '0; r0_di = '0;
        r1_valid = 0; r1_we = 0; r1_addr = '0; r1_di = '0;
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (arr_valid !== 1'b0) begin failures++; $display("FAIL reset_arr_valid got=%b exp=0", arr_valid); end
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {r0_ready, r1_ready}); end
        checks++; if ({arr_we, arr_addr, arr_di} !== '0) begin failures++; $display("FAIL reset_arr_bus got=%h exp=0", {arr_we, arr_addr, arr_di}); end
        checks++; if (r0_do !== 32'd99 || r1_do !== 32'd99) begin failures++; $display("FAIL reset_do got=%0d/%0d exp=99", r0_do, r1_do); end
    endtask

    task automatic test_single_read;
        do_reset;
        r0_valid = 1; r0_addr = 8'd3; r0_we = 0;
        #1;
        checks++; if (arr_valid !== 1'b0) begin failures++; $display("FAIL read_bubble got=%b exp=0", arr_valid); end
        tick;
        checks++; if (arr_valid !== 1'b1 || arr_addr !== 8'd3) begin failures++; $display("FAIL read_present got=%b/%0d exp=1/3", arr_valid, arr_addr); end
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL read_ready got=%b%b exp=10", r0_ready, r1_ready); end
        checks++; if (r0_do !== 32'd42) begin failures++; $display("FAIL read_data got=%0d exp=42", r0_do); end
        tick;
        r0_valid = 0;
        tick;
        checks++; if (busy !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL read_idle got=%b%b exp=00", busy, r1_ready); end
    endtask

    task automatic test_write_pass;
        do_reset;
        r1_valid = 1; r1_we = 1; r1_addr = 8'd5; r1_di = 32'd7;
        tick;
        checks++; if ({arr_we, arr_addr, arr_di} !== {1'b1, 8'd5, 32'd7}) begin failures++; $display("FAIL write_route got=%b/%0d/%0d exp=1/5/7", arr_we, arr_addr, arr_di); end
        checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin failures++; $display("FAIL write_ready got=%b%b exp=01", r0_ready, r1_ready); end
        tick;
        r1_valid = 0; r1_we = 0;
        tick;
        r0_valid = 1; r0_addr = 8'd5; r0_we = 0;
        tick;
        checks++; if (r0_ready !== 1'b1 || r0_do !== 32'd7) begin failures++; $display("FAIL write_readback got=%b/%0d exp=1/7", r0_ready, r0_do); end
        tick;
        r0_valid = 0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_ready [4];
        exp_ready[0] = 2'b10; exp_ready[1] = 2'b01; exp_ready[2] = 2'b10; exp_ready[3] = 2'b01;
        do_reset;
        r0_valid = 1; r0_addr = 8'd10;
        r1_valid = 1; r1_addr = 8'd11;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (busy !== 1'b1 || {r0_ready, r1_ready} !== exp_ready[i])
                begin failures++; $display("FAIL rr_order[%0d] got=busy%b rdy%b exp=busy1 rdy%b", i, busy, {r0_ready, r1_ready}, exp_ready[i]); end
        end
        r0_valid = 0; r1_valid = 0;
        tick;
    endtask

    task automatic test_stall;
        do_reset;
        stall = 1;
        r0_valid = 1; r0_addr = 8'd20;
        r1_valid = 1; r1_addr = 8'd21;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (arr_addr !== 8'd20 || {r0_ready, r1_ready} !== 2'b00 || busy !== 1'b1)
                begin failures++; $display("FAIL stall_hold[%0d] got=addr%0d rdy%b busy%b exp=addr20 rdy00 busy1", i, arr_addr, {r0_ready, r1_ready}, busy); end
        end
        stall = 0;
        #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL stall_release got=%b%b exp=10", r0_ready, r1_ready); end
        tick;
        checks++; if (arr_addr !== 8'd21 || r1_ready !== 1'b1 || r0_ready !== 1'b0) begin failures++; $display("FAIL stall_switch got=addr%0d rdy%b%b exp=addr21 rdy01", arr_addr, r0_ready, r1_ready); end
        r0_valid = 0; r1_valid = 0;
        tick;
    endtask

    task automatic test_reset_mid_grant;
        do_reset;
        // Complete one r0 transaction so the pointer moves away from its reset value.
        r0_valid = 1; r0_addr = 8'd3;
        tick; tick;
        r0_valid = 0;
        tick;
        stall = 1;
        r1_valid = 1; r1_addr = 8'd30;
        tick;
        checks++; if (busy !== 1'b1 || arr_addr !== 8'd30 || r1_ready !== 1'b0) begin failures++; $display("FAIL midrst_grant1 got=busy%b addr%0d rdy%b exp=1/30/0", busy, arr_addr, r1_ready); end
        rst = 1;
        tick;
        checks++; if (busy !== 1'b0 || arr_valid !== 1'b0 || {r0_ready, r1_ready} !== 2'b00) begin failures++; $display("FAIL midrst_idle got=busy%b av%b rdy%b%b exp=0/0/00", busy, arr_valid, r0_ready, r1_ready); end
        rst = 0; stall = 0;
        r0_valid = 1; r0_addr = 8'd31;
        tick;
        checks++; if (arr_addr !== 8'd31 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL midrst_prio got=addr%0d rdy%b%b exp=addr31 rdy10", arr_addr, r0_ready, r1_ready); end
        r0_valid = 0; r1_valid = 0;
        tick;
    endtask

    task automatic test_withdrawal;
        do_reset;
        stall = 1;
        r0_valid = 1; r0_addr = 8'd40;
        tick;
        checks++; if (busy !== 1'b1 || arr_addr !== 8'd40 || r0_ready !== 1'b0) begin failures++; $display("FAIL wd_grant got=busy%b addr%0d rdy%b exp=1/40/0", busy, arr_addr, r0_ready); end
        r0_valid = 0;
        #1;
        checks++; if (arr_valid !== 1'b0 || r0_ready !== 1'b0) begin failures++; $display("FAIL wd_drop got=av%b rdy%b exp=0/0", arr_valid, r0_ready); end
        tick;
        checks++; if (busy !== 1'b0 || {r0_ready, r1_ready} !== 2'b00) begin failures++; $display("FAIL wd_idle got=busy%b rdy%b%b exp=0/00", busy, r0_ready, r1_ready); end
        stall = 0;
        r0_valid = 1; r0_addr = 8'd41;
        r1_valid = 1; r1_addr = 8'd42;
        tick;
        checks++; if (arr_addr !== 8'd41 || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL wd_prio got=addr%0d rdy%b%b exp=addr41 rdy10", arr_addr, r0_ready, r1_ready); end
        r0_valid = 0; r1_valid = 0;
        tick;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'd99;
        mem[3] = 32'd42;
        test_reset;
        test_single_read;
        test_write_pass;
        test_back_to_back;
        test_stall;
        test_reset_mid_grant;
        test_withdrawal;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
